console_text_sequencer: RTL and testbench
=========================================

Name: console_text_sequencer

Overview:
Terminal-style write controller for the VGA text console's character buffer (NUM_ROWS x NUM_COLS cells of {color[2:0], char[6:0]}).
- Consumes a byte stream with ready/valid, maintains a cursor and interprets control codes.
- Sequences multi-cycle scroll and clear operations on the buffer.
- Arbitrates the single buffer write port between itself and direct host register writes; the host always wins.

Parameters:
NUM_ROWS, 3, text rows in buffer
NUM_COLS, 10, text columns in buffer
DEFAULT_COLOR, 3'b010, color used for blank fill cells
BLANK_CHAR, 7'h20, character code used for blank fill
(derived constants: NUM_CHARS = NUM_ROWS*NUM_COLS, ADDR_W = clog2(NUM_CHARS), ROW_W = clog2(NUM_ROWS), COL_W = clog2(NUM_COLS))

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  stream byte valid
in_data  in  8  stream byte
in_color  in  3  color for printable byte
in_ready  out  1  byte accepted when in_valid & in_ready
host_we  in  1  direct host cell write request (priority)
host_addr  in  ADDR_W  host cell index
host_wdata  in  10  host cell value {color, char}
buf_we  out  1  buffer write enable
buf_waddr  out  ADDR_W  buffer write index
buf_wdata  out  10  buffer write value
buf_raddr  out  ADDR_W  buffer read index (combinational-read buffer)
buf_rdata  in  10  buffer read data, same cycle
cursor_row  out  ROW_W  current cursor row
cursor_col  out  COL_W  current cursor column
busy  out  1  scroll or clear in progress
scroll_pulse  out  1  one-cycle pulse when a scroll completes

Behaviour:
- Reset (async, reset=1):
  - state=IDLE, cursor (0,0), index counter 0.
  - buf_we=0, buf_waddr=0, buf_wdata=0, buf_raddr=0, busy=0, scroll_pulse=0.
  - in_ready=1 once reset releases (host_we=0).
- Reset mid-scroll or mid-clear aborts immediately; buffer contents are left as-is.
- Arbitration:
  - host_we=1 drives buf_we=1, buf_waddr=host_addr, buf_wdata=host_wdata, combinationally in the same cycle.
  - In that cycle: in_ready=0 and the sequencer holds its index (no progress, no lost step).
- in_ready = (state==IDLE) & ~host_we.
- States: IDLE, SCROLL, CLEAR.
- IDLE, accepted byte b, with write issued in the same cycle as acceptance:
  - 0x20-0x7E: write {in_color, b[6:0]} to row*NUM_COLS+col, then advance col.
    - If col was NUM_COLS-1: col=0 and row+1.
    - If row was NUM_ROWS-1: row stays and go SCROLL.
  - 0x0A (LF): col=0; row+1, or SCROLL if on last row. No write.
  - 0x0D (CR): col=0. No write.
  - 0x08 (BS): col-1 if col>0, otherwise no change. No erase.
  - 0x0C (FF): go CLEAR with idx=0 and clear_all=1; cursor set to (0,0) on entry.
  - Any other byte is consumed with no effect.
- SCROLL: idx runs NUM_COLS .. NUM_CHARS-1.
  - Per non-stalled cycle: buf_raddr=idx, buf_we=1, buf_waddr=idx-NUM_COLS, buf_wdata=buf_rdata, idx+1.
  - After the last copy: go CLEAR with idx=NUM_CHARS-NUM_COLS and clear_all=0.
- CLEAR:
  - Per non-stalled cycle: write {DEFAULT_COLOR, BLANK_CHAR} to idx, idx+1.
  - At idx=NUM_CHARS-1: return to IDLE. If clear_all=0, assert scroll_pulse for exactly 1 cycle in that final cycle.
- busy = (state != IDLE).
- Default scroll duration is 20 copy cycles + 10 clear cycles = 30 cycles, plus one cycle per host stall.
- buf_raddr = 0 whenever state is not SCROLL.
- Width rules: all index arithmetic is in ADDR_W bits; row*NUM_COLS is computed with shift-add when NUM_COLS=10, generic multiply otherwise.

Decomposition:
- Shared package console_pkg: cell width (10), char/color field positions, state enum {IDLE, SCROLL, CLEAR}, control code constants (BS 0x08, LF 0x0A, FF 0x0C, CR 0x0D), BLANK_CHAR, DEFAULT_COLOR.
- No sub-module: single FSM plus cursor logic. The write-port mux is inline.

Test Plan:
- Reset, then stream "AB" (color 3'b101) -> buf writes idx0=0x2C1 and idx1=0x2C2 in the acceptance cycles; cursor ends at (0,2).
- Stream 30 bytes 'a' -> on the 30th byte, write idx29, then busy for 30 cycles: 20 copies (w=idx-10, data=r[idx]), then blanks 0x120 to idx20-29; scroll_pulse once; cursor (2,0); in_ready=0 throughout.
- During that scroll, assert host_we for 3 cycles at copy step 5 -> host writes appear on the port, the copy sequence resumes at step 5 unaltered, and busy lasts 33 cycles.
- Bytes 'X', 0x0D, 0x08, 0x0A -> cursor (0,1), (0,0), (0,0) (no BS underflow), (1,0); only 1 buffer write issued.
- Byte 0x0C from cursor (2,7) -> 30 blank writes idx0-29; cursor (0,0); no scroll_pulse.
- Assert reset at copy step 10 -> all outputs 0 immediately; after release, state IDLE, cursor (0,0), in_ready=1.

Source files
------------

// File: rtl/console_pkg.sv
// Shared definitions for the console text sequencer.
// Geometry constants, cell payload layout ({color[9:7], char[6:0]}),
// sequencer state encoding, control codes and blank-fill values.
package console_pkg;

    localparam int unsigned NUM_ROWS  = 3;
    localparam int unsigned NUM_COLS  = 10;
    localparam int unsigned NUM_CHARS = NUM_ROWS * NUM_COLS;
    localparam int unsigned ADDR_W    = $clog2(NUM_CHARS);
    localparam int unsigned ROW_W     = $clog2(NUM_ROWS);
    localparam int unsigned COL_W     = $clog2(NUM_COLS);

    localparam int unsigned CHAR_W  = 7;
    localparam int unsigned COLOR_W = 3;
    localparam int unsigned CELL_W  = CHAR_W + COLOR_W;

    // One buffer cell: color in the upper bits, character code in the lower bits.
    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [CHAR_W-1:0]  ch;
    } cell_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        CLEAR  = 2'd2
    } state_e;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    localparam logic [CHAR_W-1:0]  BLANK_CHAR    = 7'h20;
    localparam logic [COLOR_W-1:0] DEFAULT_COLOR = 3'b010;
    localparam cell_t              BLANK_CELL    = '{color: DEFAULT_COLOR, ch: BLANK_CHAR};

    // Linear cell index row*NUM_COLS+col; shift-add for the common 10-column layout.
    function automatic logic [ADDR_W-1:0] cell_index(input logic [ROW_W-1:0] row,
                                                      input logic [COL_W-1:0] col);
        logic [ADDR_W-1:0] r;
        r = ADDR_W'(row);
        if (NUM_COLS == 10) begin
            return (r << 3) + (r << 1) + ADDR_W'(col);
        end
        return ADDR_W'(r * ADDR_W'(NUM_COLS)) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/console_text_sequencer_if.sv
// Byte stream, host cell-write and character buffer port bundle.
// master: stream/host source and buffer owner; slave: the sequencer.
interface console_text_sequencer_if;

    logic                                in_valid;
    logic [7:0]                          in_data;
    logic [console_pkg::COLOR_W-1:0]     in_color;
    logic                                in_ready;

    logic                                host_we;
    logic [console_pkg::ADDR_W-1:0]      host_addr;
    console_pkg::cell_t                  host_wdata;

    logic                                buf_we;
    logic [console_pkg::ADDR_W-1:0]      buf_waddr;
    console_pkg::cell_t                  buf_wdata;
    logic [console_pkg::ADDR_W-1:0]      buf_raddr;
    console_pkg::cell_t                  buf_rdata;

    modport master (
        output in_valid, in_data, in_color, host_we, host_addr, host_wdata, buf_rdata,
        input  in_ready, buf_we, buf_waddr, buf_wdata, buf_raddr
    );

    modport slave (
        input  in_valid, in_data, in_color, host_we, host_addr, host_wdata, buf_rdata,
        output in_ready, buf_we, buf_waddr, buf_wdata, buf_raddr
    );

endinterface

// File: rtl/console_text_sequencer.sv
// Terminal-style writer for the text console character buffer.
// Ports: clk/reset (async, active-high); bus (slave) carries the byte stream
// (in_valid/in_data/in_color/in_ready), host direct cell writes (host_*) and
// the buffer write/read port (buf_*); cursor_row/cursor_col give the cursor,
// busy flags a scroll/clear sequence, scroll_pulse marks the end of a scroll.
// Host writes always own the buffer port and freeze the sequencer for that cycle.
module console_text_sequencer
    import console_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    console_text_sequencer_if.slave  bus,
    output logic [ROW_W-1:0]         cursor_row,
    output logic [COL_W-1:0]         cursor_col,
    output logic                     busy,
    output logic                     scroll_pulse
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              clear_all_q, clear_all_d;

    logic accept;
    logic printable;
    logic line_feed;
    logic last_col;
    logic last_row;
    logic last_idx;

    // Next-state, cursor update and buffer port mux.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        row_d         = row_q;
        col_d         = col_q;
        clear_all_d   = clear_all_q;
        line_feed     = 1'b0;
        scroll_pulse  = 1'b0;
        bus.buf_we    = 1'b0;
        bus.buf_waddr = '0;
        bus.buf_wdata = '0;
        bus.buf_raddr = '0;

        bus.in_ready = (state_q == IDLE) && !bus.host_we;
        accept       = bus.in_valid && bus.in_ready;
        printable    = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);
        last_col     = (col_q == COL_W'(NUM_COLS - 1));
        last_row     = (row_q == ROW_W'(NUM_ROWS - 1));
        last_idx     = (idx_q == ADDR_W'(NUM_CHARS - 1));

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (bus.in_data)
                        CC_LF: line_feed = 1'b1;
                        CC_CR: col_d = '0;
                        CC_BS: begin
                            if (col_q != '0) col_d = col_q - COL_W'(1);
                        end
                        CC_FF: begin
                            state_d     = CLEAR;
                            idx_d       = '0;
                            clear_all_d = 1'b1;
                            row_d       = '0;
                            col_d       = '0;
                        end
                        default: begin
                            if (printable) begin
                                bus.buf_we    = 1'b1;
                                bus.buf_waddr = cell_index(row_q, col_q);
                                bus.buf_wdata = '{color: bus.in_color, ch: bus.in_data[6:0]};
                                if (last_col) line_feed = 1'b1;
                                else          col_d = col_q + COL_W'(1);
                            end
                        end
                    endcase
                end
                // Wrap or LF: new line, scrolling instead when already on the bottom row.
                if (line_feed) begin
                    col_d = '0;
                    if (last_row) begin
                        state_d = SCROLL;
                        idx_d   = ADDR_W'(NUM_COLS);
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end

            SCROLL: begin
                bus.buf_raddr = idx_q;
                if (!bus.host_we) begin
                    bus.buf_we    = 1'b1;
                    bus.buf_waddr = idx_q - ADDR_W'(NUM_COLS);
                    bus.buf_wdata = bus.buf_rdata;
                    if (last_idx) begin
                        state_d     = CLEAR;
                        idx_d       = ADDR_W'(NUM_CHARS - NUM_COLS);
                        clear_all_d = 1'b0;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end

            CLEAR: begin
                if (!bus.host_we) begin
                    bus.buf_we    = 1'b1;
                    bus.buf_waddr = idx_q;
                    bus.buf_wdata = BLANK_CELL;
                    if (last_idx) begin
                        state_d      = IDLE;
                        idx_d        = '0;
                        scroll_pulse = !clear_all_q;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Host write has absolute priority on the buffer port.
        if (bus.host_we) begin
            bus.buf_we    = 1'b1;
            bus.buf_waddr = bus.host_addr;
            bus.buf_wdata = bus.host_wdata;
        end
    end

    // State, index and cursor registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            clear_all_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            clear_all_q <= clear_all_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign cursor_row = row_q;
    assign cursor_col = col_q;

endmodule

// File: tb/tb_console_text_sequencer.sv
// Self-checking bench for console_text_sequencer: directed scenarios followed by
// a randomized byte/host-write stream checked against a screen-level model.
module tb_console_text_sequencer;
    import console_pkg::*;

    localparam int BLANK = 32'h120;
    localparam int BUDGET = 200;

    logic             clk = 1'b0;
    logic             reset;
    logic [ROW_W-1:0] cursor_row;
    logic [COL_W-1:0] cursor_col;
    logic             busy;
    logic             scroll_pulse;

    console_text_sequencer_if bus ();

    console_text_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .cursor_row   (cursor_row),
        .cursor_col   (cursor_col),
        .busy         (busy),
        .scroll_pulse (scroll_pulse)
    );

    always #5 clk = ~clk;

    // Character buffer with combinational read.
    logic [CELL_W-1:0] mem [NUM_CHARS] = '{default: '0};
    assign bus.buf_rdata = (int'(bus.buf_raddr) < NUM_CHARS) ? cell_t'(mem[bus.buf_raddr]) : '0;
    always @(posedge clk) begin
        if (bus.buf_we && int'(bus.buf_waddr) < NUM_CHARS) mem[bus.buf_waddr] <= bus.buf_wdata;
    end

    // Write log and pulse counter, sampled mid-cycle.
    int log_a[$];
    int log_d[$];
    int pulse_cnt = 0;
    always @(negedge clk) begin
        if (bus.buf_we === 1'b1) begin
            log_a.push_back(int'(bus.buf_waddr));
            log_d.push_back(int'(bus.buf_wdata));
        end
        if (scroll_pulse === 1'b1) pulse_cnt++;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Screen-level reference: cells as row-major text, cursor as (row,col).
    int ref_mem [NUM_CHARS];
    int ref_row = 0;
    int ref_col = 0;
    int exp_a[$];
    int exp_d[$];

    task automatic ref_scroll();
        for (int i = 0; i < NUM_CHARS; i++)
            ref_mem[i] = (i < NUM_CHARS - NUM_COLS) ? ref_mem[i + NUM_COLS] : BLANK;
    endtask

    task automatic ref_byte(input int b, input int color, output bit scrolled);
        scrolled = 1'b0;
        if (b >= 32'h20 && b <= 32'h7E) begin
            ref_mem[ref_row * NUM_COLS + ref_col] = (color << 7) | (b & 32'h7F);
            ref_col++;
        end else if (b == 32'h0A) begin
            ref_col = NUM_COLS;
        end else if (b == 32'h0D) begin
            ref_col = 0;
        end else if (b == 32'h08) begin
            if (ref_col > 0) ref_col--;
        end else if (b == 32'h0C) begin
            for (int i = 0; i < NUM_CHARS; i++) ref_mem[i] = BLANK;
            ref_row = 0;
            ref_col = 0;
        end
        if (ref_col == NUM_COLS) begin
            ref_col = 0;
            if (ref_row == NUM_ROWS - 1) begin
                ref_scroll();
                scrolled = 1'b1;
            end else begin
                ref_row++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int b, input int color);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(b);
        bus.in_color = 3'(color);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < BUDGET) begin
            tick();
            cycles++;
        end
        if (cycles >= BUDGET) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        ref_row = 0;
        ref_col = 0;
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
        exp_a.delete();
        exp_d.delete();
        pulse_cnt = 0;
    endtask

    task automatic check_log(input string tag);
        int diff;
        diff = 0;
        check({tag, "_len"}, 32'(log_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i >= log_a.size()) diff++;
            else if (log_a[i] != exp_a[i] || log_d[i] != exp_d[i]) diff++;
        end
        check({tag, "_entries"}, 32'(diff), 32'd0);
    endtask

    task automatic check_mem(input string tag);
        int diff;
        diff = 0;
        for (int i = 0; i < NUM_CHARS; i++) if (int'(mem[i]) != ref_mem[i]) diff++;
        check(tag, 32'(diff), 32'd0);
    endtask

    task automatic check_cursor(input string tag, input int r, input int c);
        check({tag, "_row"}, 32'(cursor_row), 32'(r));
        check({tag, "_col"}, 32'(cursor_col), 32'(c));
    endtask

    // Fill the screen with 'a' in random colors; expected log holds the writes and the scroll.
    task automatic fill_screen(input bit expect_scroll_log);
        int colors [NUM_CHARS];
        bit s;
        for (int i = 0; i < NUM_CHARS; i++) colors[i] = int'($urandom_range(0, 7));
        for (int i = 0; i < NUM_CHARS; i++) begin
            exp_a.push_back(i);
            exp_d.push_back((colors[i] << 7) | 32'h61);
        end
        if (expect_scroll_log) begin
            for (int k = 0; k < NUM_CHARS - NUM_COLS; k++) begin
                exp_a.push_back(k);
                exp_d.push_back((colors[k + NUM_COLS] << 7) | 32'h61);
            end
        end
        for (int i = 0; i < NUM_CHARS - 1; i++) begin
            send(32'h61, colors[i]);
            ref_byte(32'h61, colors[i], s);
        end
        ref_mem[NUM_CHARS - 1] = (colors[NUM_CHARS - 1] << 7) | 32'h61;
        send(32'h61, colors[NUM_CHARS - 1]);
    endtask

    function automatic int pick_byte();
        int r;
        r = int'($urandom_range(0, 15));
        if (r <= 8) return int'($urandom_range(32'h20, 32'h7E));
        if (r == 9) return 32'h0A;
        if (r == 10) return 32'h0D;
        if (r == 11) return 32'h08;
        if (r == 12) return ($urandom_range(0, 3) == 0) ? 32'h0C : 32'h0D;
        if (r == 13) return int'($urandom_range(0, 31));
        return int'($urandom_range(32'h7F, 32'hFF));
    endfunction

    initial begin
        int cycles;
        int rdy_hi;
        int hd [3];
        bit s;

        for (int i = 0; i < NUM_CHARS; i++) ref_mem[i] = 0;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_color   = '0;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;

        // Reset values.
        tick();
        tick();
        check("rst_buf_we", 32'(bus.buf_we), 32'd0);
        check("rst_buf_waddr", 32'(bus.buf_waddr), 32'd0);
        check("rst_buf_wdata", 32'(bus.buf_wdata), 32'd0);
        check("rst_buf_raddr", 32'(bus.buf_raddr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulse", 32'(scroll_pulse), 32'd0);
        check_cursor("rst_cursor", 0, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // "AB" in color 5.
        clear_log();
        send(32'h41, 5); ref_byte(32'h41, 5, s);
        send(32'h42, 5); ref_byte(32'h42, 5, s);
        exp_a = '{0, 1};
        exp_d = '{32'h2C1, 32'h2C2};
        check_log("ab");
        check_cursor("ab_cursor", 0, 2);

        // Full screen then scroll.
        do_reset();
        clear_log();
        fill_screen(1'b1);
        ref_scroll();
        ref_row = NUM_ROWS - 1;
        ref_col = 0;
        for (int i = 0; i < NUM_COLS; i++) begin
            exp_a.push_back(NUM_CHARS - NUM_COLS + i);
            exp_d.push_back(BLANK);
        end
        cycles = 0;
        rdy_hi = 0;
        while (busy && cycles < BUDGET) begin
            if (bus.in_ready) rdy_hi++;
            tick();
            cycles++;
        end
        check("scroll_busy_cycles", 32'(cycles), 32'd30);
        check("scroll_in_ready_low", 32'(rdy_hi), 32'd0);
        check("scroll_pulse_cnt", 32'(pulse_cnt), 32'd1);
        check_log("scroll");
        check_cursor("scroll_cursor", 2, 0);
        check_mem("scroll_mem");

        // Scroll with a 3-cycle host stall at copy step 5.
        do_reset();
        clear_log();
        for (int j = 0; j < 3; j++) hd[j] = int'($urandom_range(0, 1023));
        fill_screen(1'b0);
        for (int k = 0; k < NUM_CHARS - NUM_COLS; k++) begin
            if (k == 5) begin
                for (int j = 0; j < 3; j++) begin
                    exp_a.push_back(j);
                    exp_d.push_back(hd[j]);
                end
            end
            exp_a.push_back(k);
            exp_d.push_back(ref_mem[k + NUM_COLS]);
        end
        for (int i = 0; i < NUM_COLS; i++) begin
            exp_a.push_back(NUM_CHARS - NUM_COLS + i);
            exp_d.push_back(BLANK);
        end
        ref_scroll();
        for (int j = 0; j < 3; j++) ref_mem[j] = hd[j];
        ref_row = NUM_ROWS - 1;
        ref_col = 0;
        cycles = 0;
        while (busy && cycles < BUDGET) begin
            if (cycles >= 5 && cycles < 8) begin
                bus.host_we    = 1'b1;
                bus.host_addr  = ADDR_W'(cycles - 5);
                bus.host_wdata = cell_t'(CELL_W'(hd[cycles - 5]));
            end else begin
                bus.host_we = 1'b0;
            end
            tick();
            cycles++;
        end
        bus.host_we = 1'b0;
        check("stall_busy_cycles", 32'(cycles), 32'd33);
        check("stall_pulse_cnt", 32'(pulse_cnt), 32'd1);
        check_log("stall");
        check_mem("stall_mem");

        // Control codes: X, CR, BS at column 0, LF.
        do_reset();
        clear_log();
        send(32'h58, 3); ref_byte(32'h58, 3, s);
        check_cursor("ctl_x", 0, 1);
        send(32'h0D, 0); ref_byte(32'h0D, 0, s);
        check_cursor("ctl_cr", 0, 0);
        send(32'h08, 0); ref_byte(32'h08, 0, s);
        check_cursor("ctl_bs", 0, 0);
        send(32'h0A, 0); ref_byte(32'h0A, 0, s);
        check_cursor("ctl_lf", 1, 0);
        check("ctl_writes", 32'(log_a.size()), 32'd1);

        // Form feed from (2,7).
        do_reset();
        send(32'h0A, 0); ref_byte(32'h0A, 0, s);
        send(32'h0A, 0); ref_byte(32'h0A, 0, s);
        for (int i = 0; i < 7; i++) begin
            int b, c;
            b = int'($urandom_range(32'h20, 32'h7E));
            c = int'($urandom_range(0, 7));
            send(b, c);
            ref_byte(b, c, s);
        end
        check_cursor("ff_pre", 2, 7);
        clear_log();
        send(32'h0C, 0); ref_byte(32'h0C, 0, s);
        check_cursor("ff_cursor", 0, 0);
        wait_idle(cycles);
        check("ff_busy_cycles", 32'(cycles), 32'd30);
        for (int i = 0; i < NUM_CHARS; i++) begin
            exp_a.push_back(i);
            exp_d.push_back(BLANK);
        end
        check_log("ff");
        check("ff_pulse_cnt", 32'(pulse_cnt), 32'd0);
        check_mem("ff_mem");

        // Reset at copy step 10.
        do_reset();
        clear_log();
        fill_screen(1'b0);
        for (int i = 0; i < 10; i++) tick();
        #1 reset = 1'b1;
        #1;
        check("abort_buf_we", 32'(bus.buf_we), 32'd0);
        check("abort_buf_waddr", 32'(bus.buf_waddr), 32'd0);
        check("abort_buf_wdata", 32'(bus.buf_wdata), 32'd0);
        check("abort_buf_raddr", 32'(bus.buf_raddr), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pulse", 32'(scroll_pulse), 32'd0);
        check_cursor("abort_cursor", 0, 0);
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check_cursor("abort_post", 0, 0);
        for (int k = 0; k < 10; k++) ref_mem[k] = ref_mem[k + NUM_COLS];
        ref_row = 0;
        ref_col = 0;
        check("abort_pulse_cnt", 32'(pulse_cnt), 32'd0);
        check_mem("abort_mem");

        // Randomized stream with interleaved host writes.
        for (int op = 0; op < 250; op++) begin
            int b, c, ha, hv, p0;
            b = pick_byte();
            c = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                ha = int'($urandom_range(0, NUM_CHARS - 1));
                hv = int'($urandom_range(0, 1023));
                bus.host_we    = 1'b1;
                bus.host_addr  = ADDR_W'(ha);
                bus.host_wdata = cell_t'(CELL_W'(hv));
                bus.in_valid   = 1'b1;
                bus.in_data    = 8'(b);
                bus.in_color   = 3'(c);
                #1;
                check("rnd_stall_ready", 32'(bus.in_ready), 32'd0);
                check("rnd_host_port", {21'(0), bus.buf_we, bus.buf_waddr, bus.buf_wdata},
                      {21'(0), 1'b1, ADDR_W'(ha), CELL_W'(hv)});
                tick();
                bus.host_we  = 1'b0;
                bus.in_valid = 1'b0;
                ref_mem[ha] = hv;
            end
            p0 = pulse_cnt;
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(b);
            bus.in_color = 3'(c);
            #1;
            check("rnd_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            bus.in_valid = 1'b0;
            ref_byte(b, c, s);
            wait_idle(cycles);
            check("rnd_pulse", 32'(pulse_cnt - p0), 32'(s));
            check_cursor("rnd_cursor", ref_row, ref_col);
            check_mem("rnd_mem");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
